alu_result_misr: RTL and testbench

- Response-side companion to the ALU stimulus path. It consumes a stream of 32-bit ALU results (e.g. from xor32) over a valid/ready handshake.
- Results are compacted into a multiple-input signature register (MISR), and the final signature is compared against a golden value.
- Provides on-chip pass/fail for ALU self-test, replacing manual inspection of monitored results.

---
 rtl/alu_result_misr.sv | 150 +++++++++++++++
 tb/tb_alu_result_misr.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_misr.sv
// rtl/alu_result_misr.sv - MISR compaction of ALU results with golden-signature compare
//
// Purpose:
//   Accepts a run of ALU result words over a valid/ready handshake and folds
//   them into a multiple-input signature register. At the end of the run the
//   signature is compared with a golden value, giving an on-chip pass/fail.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset (highest priority)
//   start         in   one-cycle pulse; begins a run (accepted in IDLE/DONE only)
//   num_vectors   in   COUNT_W  number of results in the run; latched on start
//   golden        in   WIDTH    expected signature; latched on start
//   result_valid  in   result word valid
//   result        in   WIDTH    ALU result word
//   result_ready  out  result accepted this cycle (COLLECT only)
//   busy          out  run in progress (COLLECT or COMPARE)
//   done          out  run finished; held until next accepted start or reset
//   pass          out  signature matched golden; meaningful while done=1
//   signature     out  WIDTH    current MISR value
//   vec_count     out  COUNT_W  results accepted in the current run

module alu_result_misr #(
  parameter int                 WIDTH   = 32,
  parameter int                 COUNT_W = 8,
  parameter logic [WIDTH-1:0]   POLY    = 32'h04C11DB7,
  parameter logic [WIDTH-1:0]   SEED    = 32'hFFFFFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_vectors,
  input  logic [WIDTH-1:0]   golden,
  input  logic               result_valid,
  input  logic [WIDTH-1:0]   result,
  output logic               result_ready,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [WIDTH-1:0]   signature,
  output logic [COUNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] num_q, num_d;
  logic [WIDTH-1:0]   golden_q, golden_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic               xfer;
  logic [COUNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0]   misr_next;

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    golden_d = golden_q;
    done_d   = done_q;
    pass_d   = pass_q;

    // Handshake outputs depend only on state so ready never combinationally
    // depends on valid.
    result_ready = (state_q == S_COLLECT);
    busy         = (state_q == S_COLLECT) || (state_q == S_COMPARE);

    xfer    = result_valid && result_ready;
    cnt_inc = cnt_q + COUNT_W'(1);

    // Shift left, fold the outgoing MSB back through the tap mask, then
    // merge the incoming word across all bits.
    misr_next = {sig_q[WIDTH-2:0], 1'b0}
              ^ ({WIDTH{sig_q[WIDTH-1]}} & POLY)
              ^ result;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d    = num_vectors;
          golden_d = golden;
          sig_d    = SEED;
          cnt_d    = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          // An empty run still goes through COMPARE so done/pass behave
          // identically for every run length.
          state_d  = (num_vectors != '0) ? S_COLLECT : S_COMPARE;
        end
      end

      S_COLLECT: begin
        if (xfer) begin
          sig_d = misr_next;
          cnt_d = cnt_inc;
          // The run ends on the final transfer, so the counter cannot wrap
          // even with num_vectors at its maximum.
          if (cnt_inc == num_q) begin
            state_d = S_COMPARE;
          end
        end
      end

      S_COMPARE: begin
        pass_d  = (sig_q == golden_q);
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sig_q    <= SEED;
      cnt_q    <= '0;
      num_q    <= '0;
      golden_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      golden_q <= golden_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_alu_result_misr.sv
// tb/tb_alu_result_misr.sv - self-checking bench for alu_result_misr

module tb_alu_result_misr;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  num_vectors;
  logic [31:0] golden;
  logic        result_valid;
  logic [31:0] result;
  logic        result_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] signature;
  logic [7:0]  vec_count;

  int n_checks;
  int n_fail;

  alu_result_misr dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_vectors  (num_vectors),
    .golden       (golden),
    .result_valid (result_valid),
    .result       (result),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .vec_count    (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        num;
    logic [31:0]       golden;
    int                nres;
    logic [3:0][31:0]  res;
    int                gap;
    logic [31:0]       exp_mid;
    logic [31:0]       exp_sig;
    logic              exp_pass;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n, input logic [31:0] g);
    start       = 1'b1;
    num_vectors = n;
    golden      = g;
    tick();
    start       = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int k;
    result_valid = 1'b1;
    result       = d;
    k = 0;
    while (!result_ready && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) check("ready_timeout", {31'd0, result_ready}, 32'd1);
    tick();
    result_valid = 1'b0;
  endtask

  // After the last transfer (or after start for an empty run) the block
  // spends one cycle in COMPARE, so done must rise exactly one cycle later.
  task automatic finish_run(input string tag, input logic [7:0] n,
                            input logic [31:0] exp_sig, input logic exp_pass);
    check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_cmp"},   {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_done"},  {31'd0, done},      32'd1);
    check({tag, "_pass"},  {31'd0, pass},      {31'd0, exp_pass});
    check({tag, "_sig"},   signature,          exp_sig);
    check({tag, "_cnt"},   {24'd0, vec_count}, {24'd0, n});
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_ready"}, {31'd0, result_ready}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    do_start(v.num, v.golden);
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < v.nres; i++) begin
      send_word(v.res[i]);
      if (i == 0) begin
        for (int g = 0; g < v.gap; g++) begin
          tick();
          check({tag, "_gap_sig"}, signature, v.exp_mid);
          check({tag, "_gap_cnt"}, {24'd0, vec_count}, 32'd1);
        end
      end
    end
    finish_run(tag, v.num, v.exp_sig, v.exp_pass);
  endtask

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
  endfunction

  initial begin
    logic [31:0] model;

    n_checks = 0;
    n_fail   = 0;

    tbl[0] = '{num: 8'd0, golden: 32'hFFFFFFFF, nres: 0, res: '0, gap: 0,
               exp_mid: 32'hFFFFFFFF, exp_sig: 32'hFFFFFFFF, exp_pass: 1'b1};
    tbl[1] = '{num: 8'd1, golden: 32'hFB3EE249, nres: 1, res: {96'd0, 32'h00000000}, gap: 0,
               exp_mid: 32'hFB3EE249, exp_sig: 32'hFB3EE249, exp_pass: 1'b1};
    tbl[2] = '{num: 8'd2, golden: 32'hF2BCD924, nres: 2, res: {64'd0, 32'h00000001, 32'h00000000}, gap: 3,
               exp_mid: 32'hFB3EE249, exp_sig: 32'hF2BCD924, exp_pass: 1'b1};
    tbl[3] = '{num: 8'd2, golden: 32'hF2BCD925, nres: 2, res: {64'd0, 32'h00000001, 32'h00000000}, gap: 0,
               exp_mid: 32'hFB3EE249, exp_sig: 32'hF2BCD924, exp_pass: 1'b0};
    tbl[4] = '{num: 8'd1, golden: 32'h04C11DB6, nres: 1, res: {96'd0, 32'hFFFFFFFF}, gap: 0,
               exp_mid: 32'h04C11DB6, exp_sig: 32'h04C11DB6, exp_pass: 1'b1};

    reset        = 1'b1;
    start        = 1'b0;
    num_vectors  = 8'd0;
    golden       = 32'd0;
    result_valid = 1'b0;
    result       = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_sig",   signature,              32'hFFFFFFFF);
    check("rst_cnt",   {24'd0, vec_count},     32'd0);
    check("rst_ready", {31'd0, result_ready},  32'd0);
    check("rst_busy",  {31'd0, busy},          32'd0);
    check("rst_done",  {31'd0, done},          32'd0);
    check("rst_pass",  {31'd0, pass},          32'd0);

    // Valid words in IDLE are not consumed.
    result_valid = 1'b1;
    result       = 32'h12345678;
    tick();
    tick();
    check("idle_sig", signature, 32'hFFFFFFFF);
    check("idle_cnt", {24'd0, vec_count}, 32'd0);
    result_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i, tbl[i]);

    // Start during COLLECT is ignored.
    do_start(8'd2, 32'hF2BCD924);
    send_word(32'h00000000);
    check("ign_cnt1", {24'd0, vec_count}, 32'd1);
    start       = 1'b1;
    num_vectors = 8'd1;
    golden      = 32'h0;
    tick();
    start = 1'b0;
    check("ign_cnt_hold", {24'd0, vec_count}, 32'd1);
    check("ign_sig_hold", signature, 32'hFB3EE249);
    check("ign_busy",     {31'd0, busy}, 32'd1);
    send_word(32'h00000001);
    finish_run("ign", 8'd2, 32'hF2BCD924, 1'b1);

    // Words offered in DONE are not consumed; results stay frozen.
    result_valid = 1'b1;
    result       = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dn_ready", {31'd0, result_ready}, 32'd0);
      check("dn_sig",   signature, 32'hF2BCD924);
      check("dn_done",  {31'd0, done}, 32'd1);
      check("dn_pass",  {31'd0, pass}, 32'd1);
    end
    result_valid = 1'b0;

    // Reset mid-COLLECT with valid asserted.
    do_start(8'd3, 32'h0);
    send_word(32'h00000000);
    result_valid = 1'b1;
    result       = 32'h00000005;
    reset        = 1'b1;
    tick();
    check("mrst_sig",   signature, 32'hFFFFFFFF);
    check("mrst_cnt",   {24'd0, vec_count}, 32'd0);
    check("mrst_done",  {31'd0, done}, 32'd0);
    check("mrst_ready", {31'd0, result_ready}, 32'd0);
    check("mrst_busy",  {31'd0, busy}, 32'd0);
    reset        = 1'b0;
    result_valid = 1'b0;
    tick();
    run_vec(1, tbl[1]);

    // Maximum-length run; inputs change after start and must not matter.
    model = 32'hFFFFFFFF;
    for (int i = 0; i < 255; i++) model = misr_step(model, 32'h01010101 * i);
    do_start(8'd255, model);
    num_vectors = 8'd3;
    golden      = 32'h0;
    for (int i = 0; i < 255; i++) send_word(32'h01010101 * i);
    finish_run("max", 8'd255, model, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
